logic_unit_sequencer: RTL
=========================

LOGIC_UNIT_SEQUENCER -- requirements
Module: logic_unit_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16-bit data and 3-bit opcode.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  3  opcode (see REQ-013).
REQ-008 req_a, req_b  input  16 each  operands.
REQ-009 rsp_valid  output  1  result present.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  16  result.
REQ-012 rsp_zero, rsp_err, busy  output  1 each  result==0; illegal opcode; state != IDLE.

Function
REQ-013 Opcodes SHALL be as follows:
- 000 AND: a&b.
- 001 OR: a|b.
- 010 XOR: a^b.
- 011 NOT: ~a.
- 100 BITSEL: {15'b0, a[b[3:0]]}.
- 101 POPCNT: count of ones in a, zero-extended to 16 bits.
- 110 PARITY: {15'b0, XOR of all bits of a}.
- 111 illegal.
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-016 On accept, req_op, req_a and req_b SHALL be latched; input changes after accept SHALL have no effect on the result.
REQ-017 For opcodes 000-100 and 111, the result SHALL be registered at the accept edge and the FSM SHALL go IDLE->DONE, so rsp_valid is high in the cycle after accept (latency 1).
REQ-018 For opcodes 101 and 110, the FSM SHALL go IDLE->SCAN; a 4-bit index SHALL start at 0 and process one bit of latched a per cycle, using the accumulate-and-select datapath.
REQ-019 In SCAN, the index SHALL increment each cycle; on the edge processing index 15 the FSM SHALL go to DONE, so rsp_valid first rises 17 cycles after the accept edge.
REQ-020 The POPCNT accumulator SHALL be 5 bits wide, so 16 ones yields 16 without overflow.
REQ-021 The PARITY accumulator SHALL be 1 bit wide.
REQ-022 In DONE, rsp_valid SHALL be 1 and rsp_data, rsp_zero and rsp_err SHALL stay stable until rsp_ready is sampled high.
REQ-023 On the edge where rsp_valid && rsp_ready, the FSM SHALL go DONE->IDLE; the next request can be accepted no earlier than the following edge.
REQ-024 rsp_zero SHALL equal (rsp_data == 16'h0000) whenever rsp_valid is 1.
REQ-025 For opcode 111, rsp_data SHALL be 16'h0000, rsp_zero SHALL be 1 and rsp_err SHALL be 1; rsp_err SHALL be 0 for every other opcode.
REQ-026 rsp_ready asserted while rsp_valid is 0 SHALL be ignored.
REQ-027 req_valid asserted outside IDLE SHALL be ignored and the request SHALL NOT be queued.
REQ-028 busy SHALL be 1 in SCAN and in DONE, and 0 in IDLE.
REQ-029 An opcode of 101 or 110 with operand 0 SHALL still take the full 16 SCAN cycles.

Reset
REQ-030 When rst is 1 at a rising edge, the block SHALL enter IDLE and clear the index and accumulators.
REQ-031 During reset, outputs SHALL be rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0, and req_ready=1 from the first cycle after reset.
REQ-032 Reset SHALL take priority over any simultaneous handshake.
REQ-033 Reset in SCAN or DONE SHALL discard the operation in flight, and no response SHALL be produced for it.

Verification
REQ-034 XOR: a=16'hA5A5, b=16'hFFFF, rsp_ready=1 -> rsp_data=16'h5A5A, rsp_valid high 1 cycle after accept, rsp_zero=0.
REQ-035 POPCNT: a=16'hF0F1 -> rsp_data=16'h0009 after 17 cycles, busy high for all 17 cycles.
REQ-036 POPCNT: a=16'hFFFF -> rsp_data=16'h0010.
REQ-037 PARITY: a=16'h0007 -> rsp_data=16'h0001.
REQ-038 BITSEL with backpressure: a=16'h8000, b=16'h000F, rsp_ready=0 for 5 cycles -> rsp_data=16'h0001 held stable with rsp_valid=1; handshake on the 6th cycle; IDLE on the next cycle.
REQ-039 Illegal opcode: req_op=3'b111 -> rsp_data=0, rsp_zero=1, rsp_err=1.
REQ-040 Reset mid-scan: rst pulsed in SCAN cycle 8 of a POPCNT -> no rsp_valid, req_ready=1 next cycle; a following AND with a=16'h00FF, b=16'h0F0F returns 16'h000F.

Source files
------------

// File: rtl/logic_unit_sequencer_if.sv
// Request/response bundle for the logic unit sequencer.
// The master issues operations and consumes results; the slave is the sequencer.
interface logic_unit_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/logic_unit_sequencer.sv
// Bitwise logic unit: single-cycle ops finish at accept, POPCNT/PARITY walk
// the latched operand one bit per cycle before presenting the result.
//
//   state | meaning
//   IDLE  | ready for a request
//   SCAN  | serial POPCNT/PARITY over latched a, one bit per cycle
//   DONE  | result held until rsp_ready
module logic_unit_sequencer (
  input  logic                    clk,
  input  logic                    rst,
  logic_unit_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOT    = 3'b011;
  localparam logic [2:0] OP_BITSEL = 3'b100;
  localparam logic [2:0] OP_POPCNT = 3'b101;
  localparam logic [2:0] OP_PARITY = 3'b110;
  localparam logic [2:0] OP_ILL    = 3'b111;

  state_t      state;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [3:0]  idx;
  logic [4:0]  pop_acc;
  logic        par_acc;
  logic [15:0] data_q;
  logic        zero_q;
  logic        err_q;
  logic        valid_q;
  logic        ready_q;
  logic        busy_q;

  logic [15:0] imm_res;
  logic        scan_bit;
  logic [4:0]  pop_next;
  logic        par_next;
  logic [15:0] scan_res;

  always_comb begin
    imm_res = 16'h0000;
    case (bus.req_op)
      OP_AND:    imm_res = bus.req_a & bus.req_b;
      OP_OR:     imm_res = bus.req_a | bus.req_b;
      OP_XOR:    imm_res = bus.req_a ^ bus.req_b;
      OP_NOT:    imm_res = ~bus.req_a;
      OP_BITSEL: imm_res = {15'b0, bus.req_a[bus.req_b[3:0]]};
      default:   imm_res = 16'h0000;
    endcase
  end

  // The final SCAN edge folds in bit 15 directly so the result lands with DONE.
  always_comb begin
    scan_bit = a_q[idx];
    pop_next = pop_acc + {4'b0, scan_bit};
    par_next = par_acc ^ scan_bit;
    scan_res = (op_q == OP_POPCNT) ? {11'b0, pop_next} : {15'b0, par_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_AND;
      a_q     <= 16'h0000;
      idx     <= 4'd0;
      pop_acc <= 5'd0;
      par_acc <= 1'b0;
      data_q  <= 16'h0000;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            idx     <= 4'd0;
            pop_acc <= 5'd0;
            par_acc <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.req_op == OP_POPCNT || bus.req_op == OP_PARITY) begin
              state <= SCAN;
            end else begin
              state   <= DONE;
              valid_q <= 1'b1;
              data_q  <= imm_res;
              zero_q  <= (imm_res == 16'h0000);
              err_q   <= (bus.req_op == OP_ILL);
            end
          end
        end
        SCAN: begin
          pop_acc <= pop_next;
          par_acc <= par_next;
          idx     <= idx + 4'd1;
          if (idx == 4'd15) begin
            state   <= DONE;
            valid_q <= 1'b1;
            data_q  <= scan_res;
            zero_q  <= (scan_res == 16'h0000);
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;
endmodule
